// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus width defaults, cycle/burst type codes and
// the arbiter state encoding.
package wb_pkg;

  localparam int unsigned AdrWDefault = 30;
  localparam int unsigned DatWDefault = 32;

  // Cycle type identifiers (cti)
  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiConst   = 3'b001;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEob     = 3'b111;

  // Burst type extensions (bte)
  localparam logic [1:0] BteLinear = 2'b00;
  localparam logic [1:0] BteWrap4  = 2'b01;
  localparam logic [1:0] BteWrap8  = 2'b10;
  localparam logic [1:0] BteWrap16 = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_bus_watchdog.sv
// Bus watchdog: counts strobe cycles that have not been terminated and raises
// a one-cycle fire pulse when the wait reaches TIMEOUT cycles.
module wb_bus_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  output logic fire_o
);

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  // Fire in the TIMEOUT-th unterminated strobe cycle; a slave response wins.
  assign fire_o = stb_i && !ack_i && !err_i && (cnt_q == CntLast);

  // Next count: restart on any termination or when the owner leaves the bus.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || ack_i || err_i || fire_o) begin
      cnt_d = '0;
    end else if (stb_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter. Round-robin grant taken only from
// idle; the owner keeps the bus for its whole cyc so bursts are never split.
module wb_master_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned ADR_W   = AdrWDefault,
  parameter int unsigned DAT_W   = DatWDefault,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk48,
  input  logic               rst_n,
  // master 0
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W-1:0]   m0_dat_w,
  output logic [DAT_W-1:0]   m0_dat_r,
  input  logic [DAT_W/8-1:0] m0_sel,
  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [2:0]         m0_cti,
  input  logic [1:0]         m0_bte,
  output logic               m0_ack,
  output logic               m0_err,
  // master 1
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W-1:0]   m1_dat_w,
  output logic [DAT_W-1:0]   m1_dat_r,
  input  logic [DAT_W/8-1:0] m1_sel,
  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [2:0]         m1_cti,
  input  logic [1:0]         m1_bte,
  output logic               m1_ack,
  output logic               m1_err,
  // slave
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W-1:0]   s_dat_w,
  output logic [DAT_W/8-1:0] s_sel,
  output logic               s_we,
  output logic [2:0]         s_cti,
  output logic [1:0]         s_bte,
  output logic               s_cyc,
  output logic               s_stb,
  input  logic [DAT_W-1:0]   s_dat_r,
  input  logic               s_ack,
  input  logic               s_err,
  // status
  output logic [1:0]         grant,
  output logic               timeout_evt
);

  arb_state_e state_q;
  logic       last_owner_q;
  logic [1:0] grant_q;

  logic own0, own1;
  logic own_cyc, own_stb;
  logic wd_fire;

  assign own0 = (state_q == StOwn0);
  assign own1 = (state_q == StOwn1);

  // Arbitration FSM: grant from idle only, release when the owner drops cyc.
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      grant_q      <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_cyc && (!m1_cyc || last_owner_q)) begin
            state_q <= StOwn0;
            grant_q <= 2'b01;
          end else if (m1_cyc) begin
            state_q <= StOwn1;
            grant_q <= 2'b10;
          end
        end
        StOwn0: begin
          if (!m0_cyc) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b0;
            grant_q      <= 2'b00;
          end
        end
        StOwn1: begin
          if (!m1_cyc) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            grant_q      <= 2'b00;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  // Slave-side mux; m0 values sit on the bus when idle since they are ignored.
  always_comb begin
    s_adr   = m0_adr;
    s_dat_w = m0_dat_w;
    s_sel   = m0_sel;
    s_we    = m0_we;
    s_cti   = m0_cti;
    s_bte   = m0_bte;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    if (own1) begin
      s_adr   = m1_adr;
      s_dat_w = m1_dat_w;
      s_sel   = m1_sel;
      s_we    = m1_we;
      s_cti   = m1_cti;
      s_bte   = m1_bte;
      own_cyc = m1_cyc;
      own_stb = m1_stb;
    end else if (own0) begin
      own_cyc = m0_cyc;
      own_stb = m0_stb;
    end
  end

  // The watchdog's fire cycle withdraws the strobe so the slave drops it.
  assign s_cyc = own_cyc;
  assign s_stb = own_stb & ~wd_fire;

  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign m0_ack   = own0 & s_ack;
  assign m1_ack   = own1 & s_ack;
  assign m0_err   = own0 & (s_err | wd_fire);
  assign m1_err   = own1 & (s_err | wd_fire);

  assign grant       = grant_q;
  assign timeout_evt = wd_fire;

  wb_bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i (clk48),
    .rst_ni(rst_n),
    .clr_i (~own_cyc),
    .stb_i (own_cyc & own_stb),
    .ack_i (s_ack),
    .err_i (s_err),
    .fire_o(wd_fire)
  );

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: directed vector table, hand
// sequences for round-robin, watchdog and reset, then random traffic against
// a cycle-level ownership model.
module tb_wb_master_arbiter;
  import wb_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk48 = 1'b0;
  logic        rst_n;
  logic [29:0] m0_adr, m1_adr, s_adr;
  logic [31:0] m0_dat_w, m1_dat_w, s_dat_w, m0_dat_r, m1_dat_r, s_dat_r;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [2:0]  m0_cti, m1_cti, s_cti;
  logic [1:0]  m0_bte, m1_bte, s_bte;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_we, s_cyc, s_stb, s_ack, s_err;
  logic [1:0]  grant;
  logic        timeout_evt;
  logic        slave_auto, s_ack_v, s_err_v;

  // Auto mode acks every cycle the bus is held (masters keep stb = cyc there).
  assign s_ack = slave_auto ? s_cyc : s_ack_v;
  assign s_err = s_err_v;

  always #5 clk48 = ~clk48;

  wb_master_arbiter #(
    .ADR_W  (30),
    .DAT_W  (32),
    .TIMEOUT(TO)
  ) dut (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .m0_adr     (m0_adr),
    .m0_dat_w   (m0_dat_w),
    .m0_dat_r   (m0_dat_r),
    .m0_sel     (m0_sel),
    .m0_cyc     (m0_cyc),
    .m0_stb     (m0_stb),
    .m0_we      (m0_we),
    .m0_cti     (m0_cti),
    .m0_bte     (m0_bte),
    .m0_ack     (m0_ack),
    .m0_err     (m0_err),
    .m1_adr     (m1_adr),
    .m1_dat_w   (m1_dat_w),
    .m1_dat_r   (m1_dat_r),
    .m1_sel     (m1_sel),
    .m1_cyc     (m1_cyc),
    .m1_stb     (m1_stb),
    .m1_we      (m1_we),
    .m1_cti     (m1_cti),
    .m1_bte     (m1_bte),
    .m1_ack     (m1_ack),
    .m1_err     (m1_err),
    .s_adr      (s_adr),
    .s_dat_w    (s_dat_w),
    .s_sel      (s_sel),
    .s_we       (s_we),
    .s_cti      (s_cti),
    .s_bte      (s_bte),
    .s_cyc      (s_cyc),
    .s_stb      (s_stb),
    .s_dat_r    (s_dat_r),
    .s_ack      (s_ack),
    .s_err      (s_err),
    .grant      (grant),
    .timeout_evt(timeout_evt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       c0, s0;
    logic [2:0] cti0;
    logic       c1, s1, ack, err;
    logic [1:0] g;
    logic       scyc, sstb, a0, a1, e0, e1;
  } vec_t;

  function automatic vec_t mk(input logic c0, s0, input logic [2:0] cti0,
                              input logic c1, s1, ack, err, input logic [1:0] g,
                              input logic scyc, sstb, a0, a1, e0, e1);
    vec_t v;
    v.c0 = c0; v.s0 = s0; v.cti0 = cti0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.err = err;
    v.g = g; v.scyc = scyc; v.sstb = sstb; v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic clear_masters();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_ack_v = 1'b0; s_err_v = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tbl[$];
    int   acks[2];
    bit   cool[2];
    bit   c[2];
    logic exp_first;
    int   n;
    bit   seen;
    // random-model state
    int   owner, last, cnt;
    logic cy[2], sb[2];
    logic own_cyc, fire;
    logic [1:0] eg;
    logic [39:0] exp_bus;

    slave_auto = 1'b0;
    clear_masters();
    m0_adr = 30'h200; m1_adr = 30'h100;
    m0_dat_w = 32'h0; m1_dat_w = 32'h0;
    m0_sel = 4'hf; m1_sel = 4'hf;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_cti = CtiClassic; m1_cti = CtiClassic;
    m0_bte = BteLinear; m1_bte = BteLinear;
    s_dat_r = 32'hDEADBEEF;

    // ---- reset with both masters requesting ----
    rst_n = 1'b0; m0_cyc = 1'b1; m1_cyc = 1'b1; s_ack_v = 1'b1;
    repeat (3) @(posedge clk48);
    @(negedge clk48); #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc), 64'd0);
    chk("rst_s_stb", 64'(s_stb), 64'd0);
    chk("rst_acks", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
    chk("rst_timeout_evt", 64'(timeout_evt), 64'd0);
    rst_n = 1'b1; s_ack_v = 1'b0;
    #1 chk("rst_release_still_idle", 64'(grant), 64'd0);
    @(negedge clk48); #1;
    chk("first_grant_m0_tie", 64'(grant), 64'b01);
    chk("first_s_cyc", 64'(s_cyc), 64'd1);
    m0_cyc = 1'b0; m1_cyc = 1'b0;

    // ---- directed vector table (bus is idle, last owner m0) ----
    //             c0 s0 cti0        c1 s1 ack err  g      scyc sstb a0 a1 e0 e1
    tbl.push_back(mk(0, 0, CtiClassic, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // m1 requests
    tbl.push_back(mk(0, 0, CtiClassic, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0)); // wait 1
    tbl.push_back(mk(0, 0, CtiClassic, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0)); // wait 2
    tbl.push_back(mk(0, 0, CtiClassic, 1, 1, 1, 0, 2'b10, 1, 1, 0, 1, 0, 0)); // ack
    tbl.push_back(mk(0, 0, CtiClassic, 1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0)); // cyc held
    tbl.push_back(mk(0, 0, CtiClassic, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0)); // m1 drops
    tbl.push_back(mk(0, 0, CtiClassic, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, CtiIncr,    1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // contention
    tbl.push_back(mk(1, 1, CtiIncr,    1, 1, 1, 0, 2'b01, 1, 1, 1, 0, 0, 0)); // beat 1
    tbl.push_back(mk(1, 1, CtiIncr,    1, 1, 1, 0, 2'b01, 1, 1, 1, 0, 0, 0)); // beat 2
    tbl.push_back(mk(1, 1, CtiIncr,    1, 1, 1, 0, 2'b01, 1, 1, 1, 0, 0, 0)); // beat 3
    tbl.push_back(mk(1, 1, CtiEob,     1, 1, 1, 0, 2'b01, 1, 1, 1, 0, 0, 0)); // beat 4
    tbl.push_back(mk(0, 0, CtiClassic, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0)); // m0 drops
    tbl.push_back(mk(0, 0, CtiClassic, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0)); // idle gap
    tbl.push_back(mk(0, 0, CtiClassic, 1, 1, 1, 0, 2'b10, 1, 1, 0, 1, 0, 0)); // m1 served
    tbl.push_back(mk(0, 0, CtiClassic, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, CtiClassic, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0)); // stray stb/err
    tbl.push_back(mk(1, 1, CtiClassic, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, CtiClassic, 0, 0, 1, 1, 2'b01, 1, 1, 1, 0, 1, 0)); // ack+err
    tbl.push_back(mk(0, 0, CtiClassic, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, CtiClassic, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk48);
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0; m0_cti = tbl[i].cti0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1;
      s_ack_v = tbl[i].ack; s_err_v = tbl[i].err;
      #1;
      chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(tbl[i].g));
      chk($sformatf("vec%0d_s_cyc", i), 64'(s_cyc), 64'(tbl[i].scyc));
      chk($sformatf("vec%0d_s_stb", i), 64'(s_stb), 64'(tbl[i].sstb));
      chk($sformatf("vec%0d_ack_err", i), 64'({m0_ack, m1_ack, m0_err, m1_err}),
          64'({tbl[i].a0, tbl[i].a1, tbl[i].e0, tbl[i].e1}));
      chk($sformatf("vec%0d_timeout_evt", i), 64'(timeout_evt), 64'd0);
      if (tbl[i].g != 2'b00) begin
        chk($sformatf("vec%0d_s_adr", i), 64'(s_adr),
            (tbl[i].g == 2'b01) ? 64'h200 : 64'h100);
        chk($sformatf("vec%0d_s_cti", i), 64'(s_cti),
            (tbl[i].g == 2'b01) ? 64'(tbl[i].cti0) : 64'(CtiClassic));
      end
      if (tbl[i].a1) chk($sformatf("vec%0d_m1_dat_r", i), 64'(m1_dat_r), 64'hDEADBEEF);
    end
    m0_cti = CtiClassic;
    clear_masters();

    // ---- round-robin fairness: 10 single writes each, acked immediately ----
    // Bus is idle with m0 as last owner, so m1 goes first.
    slave_auto = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    acks[0] = 0; acks[1] = 0; cool[0] = 0; cool[1] = 0;
    exp_first = 1'b1;
    for (int k = 0; k < 200 && (acks[0] < 10 || acks[1] < 10); k++) begin
      @(negedge clk48);
      for (int i = 0; i < 2; i++) c[i] = (acks[i] < 10) && !cool[i];
      m0_cyc = c[0]; m0_stb = c[0]; m1_cyc = c[1]; m1_stb = c[1];
      #1;
      if (m0_ack || m1_ack) begin
        chk("rr_order", 64'({m1_ack, m0_ack}), exp_first ? 64'b10 : 64'b01);
        exp_first = ~exp_first;
      end
      for (int i = 0; i < 2; i++) if (!c[i]) cool[i] = 0;
      if (m0_ack) begin acks[0]++; cool[0] = 1; end
      if (m1_ack) begin acks[1]++; cool[1] = 1; end
    end
    chk("rr_m0_acks", 64'(acks[0]), 64'd10);
    chk("rr_m1_acks", 64'(acks[1]), 64'd10);
    slave_auto = 1'b0;
    clear_masters();
    repeat (2) @(negedge clk48);

    // ---- watchdog: slave never answers m0 ----
    m0_cyc = 1'b1; m0_stb = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 16; k++) begin
      @(negedge clk48);
      m1_cyc = 1'b1; m1_stb = 1'b1;
      #1;
      if (grant == 2'b01) begin
        n++;
        chk($sformatf("wd_err_c%0d", n), 64'(m0_err), 64'(n == 16));
        chk($sformatf("wd_evt_c%0d", n), 64'(timeout_evt), 64'(n == 16));
        chk($sformatf("wd_stb_c%0d", n), 64'(s_stb), 64'(n != 16));
      end
    end
    chk("wd_fire_reached", 64'(n), 64'd16);
    chk("wd_m1_no_err", 64'(m1_err), 64'd0);
    @(negedge clk48);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #1 chk("wd_after_fire_err", 64'(m0_err | timeout_evt), 64'd0);
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk48); #1;
      if (grant == 2'b10) seen = 1;
    end
    chk("wd_m1_granted_after", 64'(seen), 64'd1);
    clear_masters();
    repeat (2) @(negedge clk48);

    // ---- reset during beat 2 of an m1 burst ----
    slave_auto = 1'b1;
    @(negedge clk48);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_cti = CtiIncr;
    #1 chk("rb_idle_before", 64'(grant), 64'd0);
    @(negedge clk48); #1;
    chk("rb_beat1_ack", 64'(m1_ack), 64'd1);
    @(negedge clk48);
    rst_n = 1'b0; m0_cyc = 1'b1;
    @(negedge clk48); #1;
    chk("rb_grant", 64'(grant), 64'd0);
    chk("rb_s_cyc", 64'(s_cyc), 64'd0);
    chk("rb_no_ack", 64'({m0_ack, m1_ack}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk48); #1;
    chk("rb_m0_wins_tie", 64'(grant), 64'b01);
    slave_auto = 1'b0; m1_cti = CtiClassic;
    clear_masters();

    // ---- random traffic against an ownership model ----
    @(negedge clk48);
    rst_n = 1'b0;
    @(negedge clk48);
    rst_n = 1'b1;
    owner = -1; last = 1; cnt = 0;
    for (int k = 0; k < 800; k++) begin
      bit stall;
      @(negedge clk48);
      stall = ((k / 80) % 2) == 1;
      rst_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, stall ? 31 : 7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, stall ? 31 : 7) == 0) m1_cyc = ~m1_cyc;
      m0_stb = ($urandom_range(0, 3) != 0);
      m1_stb = ($urandom_range(0, 3) != 0);
      m0_adr = 30'($urandom()); m1_adr = 30'($urandom());
      m0_dat_w = $urandom(); m1_dat_w = $urandom();
      m0_sel = 4'($urandom()); m1_sel = 4'($urandom());
      m0_we = 1'($urandom()); m1_we = 1'($urandom());
      m0_cti = 3'($urandom()); m1_cti = 3'($urandom());
      m0_bte = 2'($urandom()); m1_bte = 2'($urandom());
      s_dat_r = $urandom();
      s_ack_v = !stall && ($urandom_range(0, 3) == 0);
      s_err_v = !stall && ($urandom_range(0, 19) == 0);
      #1;
      cy[0] = m0_cyc; cy[1] = m1_cyc; sb[0] = m0_stb; sb[1] = m1_stb;
      own_cyc = (owner >= 0) ? cy[owner] : 1'b0;
      fire = own_cyc && sb[owner] && (cnt == int'(TO) - 1) && !s_ack_v && !s_err_v;
      eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      chk("rnd_grant", 64'(grant), 64'(eg));
      chk("rnd_s_cyc", 64'(s_cyc), 64'(own_cyc));
      chk("rnd_s_stb", 64'(s_stb), 64'((owner >= 0) && sb[owner] && !fire));
      chk("rnd_m0_ack", 64'(m0_ack), 64'((owner == 0) && s_ack_v));
      chk("rnd_m1_ack", 64'(m1_ack), 64'((owner == 1) && s_ack_v));
      chk("rnd_m0_err", 64'(m0_err), 64'((owner == 0) && (s_err_v || fire)));
      chk("rnd_m1_err", 64'(m1_err), 64'((owner == 1) && (s_err_v || fire)));
      chk("rnd_timeout_evt", 64'(timeout_evt), 64'(fire));
      chk("rnd_dat_r", 64'({m0_dat_r, m1_dat_r}), 64'({s_dat_r, s_dat_r}));
      if (owner >= 0) begin
        exp_bus = (owner == 1) ? {m1_adr, m1_we, m1_cti, m1_bte, m1_sel}
                               : {m0_adr, m0_we, m0_cti, m0_bte, m0_sel};
        chk("rnd_bus_ctl", 64'({s_adr, s_we, s_cti, s_bte, s_sel}), 64'(exp_bus));
        chk("rnd_dat_w", 64'(s_dat_w), 64'((owner == 1) ? m1_dat_w : m0_dat_w));
      end
      // advance model to the next edge
      if (!rst_n) begin
        owner = -1; last = 1; cnt = 0;
      end else begin
        if (!own_cyc || s_ack_v || s_err_v || fire) cnt = 0;
        else if (sb[owner]) cnt++;
        if (owner < 0) begin
          if (cy[0] && cy[1]) owner = 1 - last;
          else if (cy[0]) owner = 0;
          else if (cy[1]) owner = 1;
        end else if (!cy[owner]) begin
          last = owner;
          owner = -1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
